// File: rtl/v6_pulse_gen.sv
// Synthetic ADC source: emits a baseline sample stream with shaped pulses (linear rise, exponential decay).
// Triggers come from an external strobe or a periodic timer; requests made while busy are counted as missed.
module v6_pulse_gen #(
    parameter int DATA_W      = 12,
    parameter int AMP_W       = 12,
    parameter int FRAC        = 6,
    parameter int RISE_SHIFT  = 2,
    parameter int DECAY_SHIFT = 4,
    parameter int BASELINE    = 100,
    parameter int HOLDOFF     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [AMP_W-1:0]  amplitude,
    input  logic              auto_en,
    input  logic [15:0]       period,
    output logic [DATA_W-1:0] adc_data,
    output logic              pulse_start,
    output logic              busy,
    output logic [7:0]        missed_cnt
);

    localparam int ACC_W    = AMP_W + FRAC + 1;
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam int RC_W     = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam int HC_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int SUM_W    = ((ACC_W > 32) ? ACC_W : 32) + 1;

    localparam logic [DATA_W-1:0] DATA_MAX  = '1;
    localparam logic [SUM_W-1:0]  BASE_EXT  = SUM_W'(BASELINE);
    localparam logic [DATA_W-1:0] BASE_CLIP =
        (BASE_EXT > SUM_W'(DATA_MAX)) ? DATA_MAX : DATA_W'(BASELINE);

    typedef enum logic [1:0] {IDLE, RISE, DECAY, HOLD} state_t;

    function automatic logic [DATA_W-1:0] sat_sample(input logic [ACC_W-1:0] a);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a >> FRAC) + BASE_EXT;
        if (sum > SUM_W'(DATA_MAX))
            return DATA_MAX;
        return sum[DATA_W-1:0];
    endfunction

    // Minimum decrement of one keeps the tail from stalling once acc>>DECAY_SHIFT reaches zero.
    function automatic logic [ACC_W-1:0] decay_step(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] d;
        d = a >> DECAY_SHIFT;
        if (d == '0)
            d = ACC_W'(1);
        return a - d;
    endfunction

    state_t            state, state_d;
    logic [ACC_W-1:0]  acc, acc_d, step, step_d, acc_dec;
    logic [AMP_W-1:0]  amp_q, amp_d;
    logic [RC_W-1:0]   rcnt, rcnt_d;
    logic [HC_W-1:0]   hcnt, hcnt_d;
    logic [7:0]        miss_d;
    logic              start_d;
    logic [15:0]       acnt;
    logic              auto_exp;
    logic              req;

    assign auto_exp = auto_en && (period != 16'd0) && (acnt >= period - 16'd1);
    assign req      = trig | auto_exp;
    assign busy     = (state != IDLE);
    assign acc_dec  = decay_step(acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acnt <= '0;
        else if (!auto_en || period == 16'd0 || auto_exp)
            acnt <= '0;
        else
            acnt <= acnt + 16'd1;
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        step_d  = step;
        amp_d   = amp_q;
        rcnt_d  = rcnt;
        hcnt_d  = hcnt;
        start_d = 1'b0;
        miss_d  = missed_cnt;

        case (state)
            IDLE: begin
                acc_d = '0;
                if (req && amplitude != '0) begin
                    amp_d   = amplitude;
                    step_d  = (ACC_W'(amplitude) << FRAC) >> RISE_SHIFT;
                    start_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = RISE;
                end
            end
            RISE: begin
                if (rcnt == RC_W'(RISE_LEN - 1)) begin
                    acc_d   = ACC_W'(amp_q) << FRAC;
                    state_d = DECAY;
                end else begin
                    acc_d  = acc + step;
                    rcnt_d = rcnt + RC_W'(1);
                end
            end
            DECAY: begin
                if (acc_dec < ACC_W'(1 << FRAC)) begin
                    acc_d   = '0;
                    hcnt_d  = '0;
                    state_d = HOLD;
                end else begin
                    acc_d = acc_dec;
                end
            end
            HOLD: begin
                if (hcnt == HC_W'(HOLDOFF - 1)) begin
                    hcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (req && state != IDLE && missed_cnt != 8'hFF)
            miss_d = missed_cnt + 8'd1;
    end

    // Sample register: adc_data tracks acc_d on the same edge, so no extra output latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            step        <= '0;
            amp_q       <= '0;
            rcnt        <= '0;
            hcnt        <= '0;
            pulse_start <= 1'b0;
            missed_cnt  <= '0;
            adc_data    <= BASE_CLIP;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            step        <= step_d;
            amp_q       <= amp_d;
            rcnt        <= rcnt_d;
            hcnt        <= hcnt_d;
            pulse_start <= start_d;
            missed_cnt  <= miss_d;
            adc_data    <= sat_sample(acc_d);
        end
    end

endmodule
